// File: rtl/fm_pkg.sv
// fm_pkg: shared defaults and types for the FM modulator slice.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: default parameter values, interpolator state type, LFSR seed/taps.
package fm_pkg;

  localparam int A_DEF = 8;   // audio sample width (signed)
  localparam int N_DEF = 18;  // phase accumulator width
  localparam int M_DEF = 5;   // phase bits into the sine LUT
  localparam int D_DEF = 4;   // DAC code width
  localparam int K_DEF = 4;   // deviation coefficient width
  localparam int L_DEF = 2;   // deviation shift-factor width
  localparam int S_DEF = 4;   // interpolation ramp length is 2^S cycles

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } interp_state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/fm_sine_lut.sv
// fm_sine_lut: phase index -> sine DAC code via quarter-wave table + symmetry.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   p    in  M  phase index (top M bits of the phase)
//   code out D  round((2^D-1)/2 * (1+sin(2*pi*(p+0.5)/2^M)))
//
// The quarter table holds the M=5, D=4 values; other M/D need a regenerated
// QTAB. p[M-2] mirrors the index (second/fourth quarter), p[M-1] negates the
// code about mid-scale; for a full-scale D-bit code (2^D-1)-x equals ~x.
module fm_sine_lut #(
  parameter int M = 5,
  parameter int D = 4
) (
  input  logic [M-1:0] p,
  output logic [D-1:0] code
);

  localparam int Q = M - 2;

  localparam logic [D-1:0] QTAB [0:7] = '{
    D'(8), D'(10), D'(11), D'(12), D'(13), D'(14), D'(15), D'(15)
  };

  logic [Q-1:0] idx;
  logic [D-1:0] q_code;

  always_comb begin
    idx    = p[M-2] ? ~p[Q-1:0] : p[Q-1:0];
    q_code = QTAB[idx];
    code   = p[M-1] ? ~q_code : q_code;
  end

endmodule

// File: rtl/fm_modulator_interp.sv
// fm_modulator_interp: interpolated audio -> frequency deviation -> phase -> sine DAC code.
// Latency: audio_i -> rf 3 clk; dac_ena/out_ena -> rf 1 clk.
// Backpressure: none; audio_valid is a fire-and-forget strobe, config is quasi-static.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   audio/audio_valid   signed sample + one-cycle strobe
//   acc_inc             carrier phase increment
//   df_inc_coef/_fact   deviation coefficient and left shift
//   multiply_sel        0: shift only, 1: multiply by coef then shift
//   dith_fact           dither magnitude (only with DITH_EN)
//   dac_ena/out_ena     per-bit and global output enables
//   rf                  DAC code
//   ramp_busy           interpolation ramp in progress
//
// Optional feature: define DITH_EN to add LFSR dither ahead of the LUT truncation.
module fm_modulator_interp
  import fm_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int D = D_DEF,
  parameter int K = K_DEF,
  parameter int L = L_DEF,
  parameter int S = S_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [A-1:0] audio,
  input  logic                audio_valid,
  input  logic [N-1:0]        acc_inc,
  input  logic [K-1:0]        df_inc_coef,
  input  logic [L-1:0]        df_inc_fact,
  input  logic                multiply_sel,
  input  logic [2:0]          dith_fact,
  input  logic [D-1:0]        dac_ena,
  input  logic                out_ena,
  output logic [D-1:0]        rf,
  output logic                ramp_busy
);

  localparam int FX = A + S;
  localparam int MW = A + K + 1;
  localparam logic [S-1:0] CNT_LAST = '1;

  // ---------------- interpolator ----------------
  interp_state_t          state;
  logic signed [FX-1:0]   cur_fx;
  logic signed [FX-1:0]   cur_hold;
  logic signed [A:0]      step;
  logic signed [A-1:0]    target;
  logic [S-1:0]           cnt;
  logic signed [FX:0]     diff;
  logic signed [A-1:0]    audio_i;

  assign audio_i   = cur_fx[FX-1:S];
  assign ramp_busy = (state == RAMP);

  // cur_hold is where cur_fx goes without a strobe. A strobe lets the
  // in-flight step complete and plans the new ramp from that value, so a
  // restart never loses the step that was already under way.
  always_comb begin
    cur_hold = cur_fx;
    if (state == RAMP) begin
      if (cnt == CNT_LAST) cur_hold = {target, {S{1'b0}}};  // snap off floor error
      else                 cur_hold = cur_fx + step;
    end
    diff = {audio[A-1], audio, {S{1'b0}}} - {cur_hold[FX-1], cur_hold};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cur_fx <= '0;
      step   <= '0;
      target <= '0;
      cnt    <= '0;
    end else begin
      cur_fx <= cur_hold;
      if (audio_valid) begin
        step   <= diff[FX:S];  // arithmetic shift right by S = floor divide
        target <= audio;
        cnt    <= '0;
        state  <= RAMP;
      end else if (state == RAMP) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) state <= IDLE;
      end
    end
  end

  // ---------------- deviation + accumulator ----------------
  logic signed [MW-1:0] a_ext;
  logic signed [MW-1:0] c_ext;
  logic signed [MW-1:0] prod;
  logic signed [MW-1:0] m;
  logic [N-1:0]         m_ext;
  logic [N-1:0]         dev;
  logic [N-1:0]         phase;

  always_comb begin
    a_ext = {{(K+1){audio_i[A-1]}}, audio_i};
    c_ext = $signed({{(A+1){1'b0}}, df_inc_coef});  // coefficient is unsigned
    prod  = a_ext * c_ext;
    m     = multiply_sel ? prod : a_ext;
    m_ext = {{(N-MW){m[MW-1]}}, m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dev   <= '0;
      phase <= '0;
    end else begin
      dev   <= m_ext << df_inc_fact;
      phase <= phase + acc_inc + dev;  // wraps mod 2^N
    end
  end

  // ---------------- LUT index (optionally dithered) ----------------
  logic [M-1:0] p;
  logic [D-1:0] lut_code;

`ifdef DITH_EN
  logic [15:0]   lfsr;
  logic [N+15:0] lfsr_wide;
  logic [N-1:0]  dith;
  logic [N-1:0]  phase_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // Dither only touches the bits below the LUT index; the phase register
  // itself stays clean so the carrier frequency is unaffected.
  always_comb begin
    lfsr_wide = {{N{1'b0}}, lfsr};
    dith      = lfsr_wide[N-1:0] & ((N'(1) << (N-M)) - N'(1));
    dith      = (dith_fact == 3'd0) ? '0 : (dith >> (3'd7 - dith_fact));
    phase_d   = phase + dith;
    p         = phase_d[N-1:N-M];
  end
`else
  wire unused_dith = ^dith_fact;
  assign p = phase[N-1:N-M];
`endif

  fm_sine_lut #(.M(M), .D(D)) u_lut (
    .p    (p),
    .code (lut_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rf <= '0;
    else     rf <= lut_code & dac_ena & {D{out_ena}};
  end

endmodule

// File: tb/tb_fm_modulator_interp.sv
// tb_fm_modulator_interp: directed bench for fm_modulator_interp.
// Latency: n/a.
// Backpressure: n/a.
module tb_fm_modulator_interp;

  logic               clk;
  logic               rst;
  logic signed [7:0]  audio;
  logic               audio_valid;
  logic [17:0]        acc_inc;
  logic [3:0]         df_inc_coef;
  logic [1:0]         df_inc_fact;
  logic               multiply_sel;
  logic [2:0]         dith_fact;
  logic [3:0]         dac_ena;
  logic               out_ena;
  logic [3:0]         rf;
  logic               ramp_busy;

  fm_modulator_interp u_dut (
    .clk          (clk),
    .rst          (rst),
    .audio        (audio),
    .audio_valid  (audio_valid),
    .acc_inc      (acc_inc),
    .df_inc_coef  (df_inc_coef),
    .df_inc_fact  (df_inc_fact),
    .multiply_sel (multiply_sel),
    .dith_fact    (dith_fact),
    .dac_ena      (dac_ena),
    .out_ena      (out_ena),
    .rf           (rf),
    .ramp_busy    (ramp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic signed [7:0] audio;
    logic              msel;
    logic [3:0]        coef;
    logic [1:0]        fact;
    logic [17:0]       acc;
    int                exp_dev;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic signed [7:0] v);
    audio       = v;
    audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
  endtask

  function automatic int lut_model(input int p);
    real x;
    x = 7.5 * (1.0 + $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 32.0));
    return $rtoi(x + 0.5);
  endfunction

  function automatic int ai();
    return int'($signed(u_dut.audio_i));
  endfunction

  int          carrier_rf [4];
  int          busy_cnt;
  logic [17:0] ph0, ph1, dexp, dgot, exp18;

  initial begin
    rst = 1'b1; audio = '0; audio_valid = 1'b0; acc_inc = 18'd65536;
    df_inc_coef = 4'd0; df_inc_fact = 2'd0; multiply_sel = 1'b0;
    dith_fact = 3'd0; dac_ena = 4'hF; out_ena = 1'b1;

    vecs[0] = '{-8'sd3,   1'b1, 4'd5,  2'd2, 18'd1000,  -60};
    vecs[1] = '{-8'sd3,   1'b0, 4'd5,  2'd2, 18'd1000,  -12};
    vecs[2] = '{8'sd64,   1'b1, 4'd15, 2'd3, 18'd4096,  7680};
    vecs[3] = '{-8'sd128, 1'b1, 4'd15, 2'd3, 18'd70000, -15360};
    vecs[4] = '{8'sd127,  1'b0, 4'd0,  2'd0, 18'd1,     127};
    vecs[5] = '{-8'sd128, 1'b1, 4'd0,  2'd1, 18'd5,     0};
    vecs[6] = '{8'sd100,  1'b1, 4'd7,  2'd1, 18'd262143, 1400};
    vecs[7] = '{-8'sd128, 1'b0, 4'd9,  2'd3, 18'd0,     -1024};

    carrier_rf[0] = 8; carrier_rf[1] = 15; carrier_rf[2] = 7; carrier_rf[3] = 0;

    // ---- reset state + carrier wrap (quarter-turn increment) ----
    @(negedge clk);
    check("reset_rf", int'(rf), 0);
    check("reset_busy", int'(ramp_busy), 0);
    check("reset_phase", int'(u_dut.phase), 0);
    check("reset_dev", int'(u_dut.dev), 0);
    check("reset_audio_i", ai(), 0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 5) check($sformatf("carrier_phase_%0d", k), int'(u_dut.phase), (k % 4) * 65536);
      check($sformatf("carrier_rf_%0d", k), int'(rf), carrier_rf[(k - 1) % 4]);
    end

    // ---- full LUT sweep, then masking ----
    acc_inc = 18'd8192;
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      tick();
      check($sformatf("lut_p%0d", (k - 1) % 32), int'(rf), lut_model((k - 1) % 32));
    end
    out_ena = 1'b0;
    tick();
    check("mask_out_ena", int'(rf), 0);
    out_ena = 1'b1;
    dac_ena = 4'b1000;
    for (int k = 35; k <= 50; k++) begin
      tick();
      check($sformatf("mask_dac_p%0d", (k - 1) % 32), int'(rf), lut_model((k - 1) % 32) & 8);
    end
    dac_ena = 4'hF;

    // ---- ramp 0 -> 64 ----
    do_reset();
    strobe(8'sd64);
    check("ramp_start_busy", int'(ramp_busy), 1);
    check("ramp_start_audio_i", ai(), 0);
    busy_cnt = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("ramp_audio_i_%0d", k), ai(), 4 * k);
      if (ramp_busy) busy_cnt++;
    end
    tick();
    check("ramp_hold", ai(), 64);
    check("ramp_idle_busy", int'(ramp_busy), 0);
    check("ramp_busy_cycles", busy_cnt, 16);

    // ---- mid-ramp restart ----
    do_reset();
    strobe(8'sd64);
    for (int k = 1; k <= 7; k++) tick();
    check("restart_pre", ai(), 28);
    strobe(8'sd0);
    check("restart_from", ai(), 32);
    check("restart_busy", int'(ramp_busy), 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("restart_audio_i_%0d", k), ai(), 32 - 2 * k);
      check($sformatf("restart_busy_%0d", k), int'(ramp_busy), (k < 16) ? 1 : 0);
    end

    // ---- deviation scaling table ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      multiply_sel = vecs[i].msel;
      df_inc_coef  = vecs[i].coef;
      df_inc_fact  = vecs[i].fact;
      acc_inc      = vecs[i].acc;
      strobe(vecs[i].audio);
      for (int k = 0; k < 17; k++) tick();
      check($sformatf("scale%0d_audio_i", i), ai(), int'(vecs[i].audio));
      tick();
      exp18 = vecs[i].exp_dev[17:0];
      check($sformatf("scale%0d_dev", i), int'(u_dut.dev), int'(exp18));
      ph0 = u_dut.phase;
      tick();
      ph1 = u_dut.phase;
      dgot = ph1 - ph0;
      dexp = vecs[i].acc + exp18;
      check($sformatf("scale%0d_phase_inc", i), int'(dgot), int'(dexp));
    end
    multiply_sel = 1'b0; df_inc_coef = 4'd0; df_inc_fact = 2'd0;

    // ---- asynchronous reset mid-ramp ----
    acc_inc = 18'd8192;
    do_reset();
    strobe(8'sd64);
    for (int k = 0; k < 5; k++) tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_rf", int'(rf), 0);
    check("arst_busy", int'(ramp_busy), 0);
    check("arst_audio_i", ai(), 0);
`ifdef DITH_EN
    check("arst_lfsr", int'(u_dut.lfsr), 1);
`endif
    @(negedge clk);
    rst = 1'b0;
    strobe(8'sd64);
    check("arst_restart_from", ai(), 0);
    tick();
    check("arst_restart_first", ai(), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_modulator_interp.md
Name: fm_modulator_interp

Overview:
- Parametrised next-generation FM modulator core: takes strobed signed audio samples (already in the clk domain), linearly interpolates between samples, scales them into a frequency deviation and drives a phase accumulator.
- A quarter-wave sine LUT turns the phase into a D-bit DAC code.
- Sits between the audio CDC stage and the DAC output pins, configured by the SPI config block.

Parameters:
- A, 8, audio sample width (signed two's complement)
- N, 18, phase accumulator width
- M, 5, phase bits into sine LUT (M>=3)
- D, 4, DAC code width
- K, 4, deviation coefficient width (unsigned)
- L, 2, deviation shift-factor width
- S, 4, interpolation log2: ramp length 2^S cycles (S>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- audio  in  A  signed audio sample
- audio_valid  in  1  one-cycle strobe, audio valid
- acc_inc  in  N  carrier phase increment (unsigned)
- df_inc_coef  in  K  deviation coefficient
- df_inc_fact  in  L  deviation left-shift amount
- multiply_sel  in  1  0: shift only; 1: multiply by coef then shift
- dith_fact  in  3  dither magnitude (used only with DITH_EN)
- dac_ena  in  D  per-bit DAC enable mask
- out_ena  in  1  global output enable
- rf  out  D  DAC code
- ramp_busy  out  1  high while interpolation ramp is active

Behaviour:
- Reset (async, all registers): cur_fx=0, step=0, ramp counter=0, ramp_busy=0, dev=0, phase=0, rf=0; LFSR (DITH_EN) = 1.
- Interpolator, state IDLE/RAMP:
  - cur_fx is A+S bits signed; audio_i = cur_fx[A+S-1:S].
  - audio_valid in IDLE or RAMP: step <= ((audio<<S) - cur_fx) >>> S (floor, A+1 bits signed); target <= audio; cnt <= 0; go RAMP. A strobe mid-ramp restarts the ramp from the current cur_fx.
  - In RAMP, each cycle: cur_fx += step, cnt++.
  - When cnt reaches 2^S-1, that cycle forces cur_fx <= target<<S (removes floor error) and returns to IDLE.
  - IDLE holds cur_fx.
  - ramp_busy = (state==RAMP), registered.
- Deviation stage (registered):
  - m = multiply_sel ? audio_i*df_inc_coef : audio_i (signed×unsigned, A+K+1 bits).
  - dev = sign_extend_N(m << df_inc_fact), truncated mod 2^N.
- Accumulator: phase <= phase + acc_inc + dev, mod 2^N; wraps silently.
- LUT: p = phase[N-1:N-M].
  - Code = round((2^D-1)/2 * (1+sin(2π(p+0.5)/2^M))).
  - Stored as a quarter-wave table of 2^(M-2) entries; mirror/negate by p[M-1:M-2].
- Output: rf <= lut_code & dac_ena & {D{out_ena}}, registered.
- Latency:
  - audio_i change -> rf effect: 3 clk (dev reg, phase reg, rf reg).
  - out_ena/dac_ena -> rf: 1 clk.
- acc_inc/coef/fact changes take effect on the next dev/phase update; no handshake. They are quasi-static from the SPI block.

Optional Feature:
- DITH_EN defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every clk.
  - Its low bits, masked to (N-M) bits and right-shifted by (7-dith_fact), are added to phase before LUT truncation (phase register itself undithered).
  - dith_fact=0 disables dither.
- Not defined: no LFSR, dith_fact ignored, p taken directly from phase.

Decomposition:
- Package fm_pkg:
  - default parameter constants (A, N, M, D, K, L, S)
  - interpolator state enum (IDLE, RAMP)
  - LFSR seed and tap constants
- Sub-module fm_sine_lut (parameters M, D): combinational quarter-wave table plus symmetry logic; input p, output code.

Test Plan:
- Carrier wrap: reset; audio=0, acc_inc=2^N/4=65536, dac_ena=4'hF, out_ena=1.
  - Required: rf repeats with period 4 clk.
  - Required: phase passes through 0,65536,131072,196608,0 (wrap).
- Ramp: audio_valid with audio=64 from cur=0, S=4.
  - Required: audio_i=4,8,…,64 over 16 clk.
  - Required: ramp_busy high exactly 16 clk, then audio_i holds 64.
- Scaling: audio_i=-3, multiply_sel=1, coef=5, fact=2.
  - Required: dev=-60 (2^N-60).
  - Required: phase increment = acc_inc-60 per clk.
  - Required: with multiply_sel=0, dev=-12.
- Mid-ramp restart: audio=64, then audio=0 strobe at cnt=7.
  - Required: new ramp starts from audio_i=32 and ends exactly at 0 after 16 clk.
- Masking: out_ena 1→0.
  - Required: rf=0 one clk later.
  - Required: dac_ena=4'b1000 passes only rf[3].
- Async reset mid-ramp: assert rst between clk edges.
  - Required: rf, ramp_busy, audio_i immediately 0.
  - Required: after release, first audio_valid ramps from 0.
  - Required: with DITH_EN, LFSR restarts at 1.
